// File: rtl/larson_pkg.sv
// Shared types and helpers for the larson scanner sequencer.
// Holds the sequencer state encoding and the one-hot decoder used by the LED stage.
package larson_pkg;

    // Widest LED bar the one-hot helper can decode.
    localparam int unsigned MAX_LEDS = 64;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        UP        = 3'd1,
        DWELL_TOP = 3'd2,
        DOWN      = 3'd3,
        DWELL_BOT = 3'd4
    } larson_state_e;

    function automatic logic [MAX_LEDS-1:0] onehot(input int unsigned idx);
        logic [MAX_LEDS-1:0] v;
        v = {{(MAX_LEDS-1){1'b0}}, 1'b1} << idx;
        return v;
    endfunction

endpackage

// File: rtl/larson_tick_gen.sv
// Step-rate prescaler: emits a one-cycle tick every PRESCALE running cycles.
// The count freezes while i_run is low so a paused bar keeps its step grid.
module larson_tick_gen #(
    parameter int PRESCALE = 1024
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign o_tick = i_run && (cnt == CNT_MAX);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_clr) begin
            cnt <= '0;
        end else if (o_tick) begin
            cnt <= '0;
        end else if (i_run) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/larson_scan_ctrl.sv
// Scanner light-bar sequencer: sweeps one lit LED up and down with a dwell at each end.
// Define LARSON_TRAIL_EN to also light the LED just behind the moving position.
module larson_scan_ctrl
    import larson_pkg::*;
#(
    parameter int N_LEDS   = 8,
    parameter int PRESCALE = 1024,
    parameter int DWELL    = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_en,
    input  logic                      i_clr,
    input  logic                      i_invert,
    output logic [N_LEDS-1:0]         o_leds,
    output logic [$clog2(N_LEDS)-1:0] o_pos,
    output logic                      o_dir,
    output logic                      o_step
);

    localparam int PW = $clog2(N_LEDS);
    localparam int DW = (DWELL < 1) ? 1 : $clog2(DWELL + 1);
    localparam logic [PW-1:0] POS_MAX   = PW'(N_LEDS - 1);
    localparam logic [DW-1:0] DWELL_LD  = DW'(DWELL);

    larson_state_e state, state_n;
    logic [PW-1:0] pos, pos_n;
    logic [DW-1:0] dwell_cnt, dwell_n;
    logic          dir, dir_n;
    logic          step_n;
    logic          tick;
    logic          run;
    logic [N_LEDS-1:0] pattern;

    // The prescaler only advances once the sweep has started.
    assign run = i_en && (state != IDLE);

    larson_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_run   (run),
        .i_clr   (i_clr),
        .o_tick  (tick)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            pos       <= '0;
            dwell_cnt <= '0;
            dir       <= 1'b0;
            o_step    <= 1'b0;
        end else begin
            state     <= state_n;
            pos       <= pos_n;
            dwell_cnt <= dwell_n;
            dir       <= dir_n;
            o_step    <= step_n;
        end
    end

    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    always_comb begin
        state_n = state;
        pos_n   = pos;
        dwell_n = dwell_cnt;
        dir_n   = dir;
        step_n  = 1'b0;

        if (i_clr) begin
            state_n = IDLE;
            pos_n   = '0;
            dwell_n = '0;
            dir_n   = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    pos_n = '0;
                    dir_n = 1'b0;
                    if (i_en) begin
                        state_n = UP;
                    end
                end
                UP: begin
                    if (tick) begin
                        pos_n  = pos + PW'(1);
                        step_n = 1'b1;
                        if (pos_n == POS_MAX) begin
                            state_n = DWELL_TOP;
                            dwell_n = DWELL_LD;
                            dir_n   = 1'b1;
                        end
                    end
                end
                DWELL_TOP: begin
                    dir_n = 1'b1;
                    if (tick) begin
                        if (dwell_cnt == '0) begin
                            state_n = DOWN;
                        end else begin
                            dwell_n = dwell_cnt - DW'(1);
                        end
                    end
                end
                DOWN: begin
                    if (tick) begin
                        pos_n  = pos - PW'(1);
                        step_n = 1'b1;
                        if (pos_n == '0) begin
                            state_n = DWELL_BOT;
                            dwell_n = DWELL_LD;
                            dir_n   = 1'b0;
                        end
                    end
                end
                DWELL_BOT: begin
                    dir_n = 1'b0;
                    if (tick) begin
                        if (dwell_cnt == '0) begin
                            state_n = UP;
                        end else begin
                            dwell_n = dwell_cnt - DW'(1);
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    pos_n   = '0;
                    dwell_n = '0;
                    dir_n   = 1'b0;
                end
            endcase
        end
    end

    // LED pattern is built from the registered position, so o_leds trails o_pos by a cycle.
    always_comb begin
        pattern = N_LEDS'(onehot(32'(pos)));
`ifdef LARSON_TRAIL_EN
        if (state == UP && pos != '0) begin
            pattern = pattern | N_LEDS'(onehot(32'(pos) - 32'd1));
        end
        if (state == DOWN && pos != POS_MAX) begin
            pattern = pattern | N_LEDS'(onehot(32'(pos) + 32'd1));
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_leds <= '0;
        end else begin
            o_leds <= pattern ^ {N_LEDS{i_invert}};
        end
    end

    assign o_pos = pos;
    assign o_dir = dir;

endmodule

// File: tb/tb_larson_scan_ctrl.sv
// Directed bench for larson_scan_ctrl: reset, sweep, pause, clear, invert and a minimal-parameter instance.
// Define LARSON_TRAIL_EN for both bench and RTL to check the trail variant.
module tb_larson_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, clr, inv;
    logic [7:0] leds;
    logic [2:0] pos;
    logic       dir, stp;

    logic       en2, clr2, inv2;
    logic [1:0] leds2;
    logic [0:0] pos2;
    logic       dir2, stp2;

    int total = 0;
    int bad   = 0;

    larson_scan_ctrl #(.N_LEDS(8), .PRESCALE(4), .DWELL(2)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_en     (en),
        .i_clr    (clr),
        .i_invert (inv),
        .o_leds   (leds),
        .o_pos    (pos),
        .o_dir    (dir),
        .o_step   (stp)
    );

    larson_scan_ctrl #(.N_LEDS(2), .PRESCALE(1), .DWELL(0)) dut2 (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_en     (en2),
        .i_clr    (clr2),
        .i_invert (inv2),
        .o_leds   (leds2),
        .o_pos    (pos2),
        .o_dir    (dir2),
        .o_step   (stp2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference sweep for N=8, DWELL=2: position/direction after k ticks since leaving IDLE.
    function automatic int m_pos(int k);
        int m;
        m = k % 20;
        if (m <= 7)  return m;
        if (m <= 10) return 7;
        if (m <= 17) return 17 - m;
        return 0;
    endfunction

    function automatic logic m_dir(int k);
        int m;
        m = k % 20;
        return (m >= 7 && m <= 16);
    endfunction

    function automatic logic [7:0] m_leds(int k);
        int m;
        int p;
        logic [7:0] v;
        m = k % 20;
        p = m_pos(k);
        v = 8'd1 << p;
`ifdef LARSON_TRAIL_EN
        if (m <= 6 && p > 0)              v = v | (8'd1 << (p - 1));
        if (m >= 10 && m <= 16 && p < 7)  v = v | (8'd1 << (p + 1));
`endif
        return v;
    endfunction

    task automatic test_reset();
        int n;
        rst_n = 1'b0; en = 1'b1; clr = 1'b0; inv = 1'b0;
        en2 = 1'b0; clr2 = 1'b0; inv2 = 1'b0;
        repeat (3) step();
        total++; if (leds !== 8'h00) begin bad++; $display("FAIL reset_leds got=%h want=00", leds); end
        total++; if (pos !== 3'd0)   begin bad++; $display("FAIL reset_pos got=%0d want=0", pos); end
        total++; if (dir !== 1'b0)   begin bad++; $display("FAIL reset_dir got=%b want=0", dir); end
        total++; if (stp !== 1'b0)   begin bad++; $display("FAIL reset_step got=%b want=0", stp); end
        rst_n = 1'b1;
        // First edge after release is IDLE->UP; first tick lands 4 edges later.
        n = 0;
        while (pos == 3'd0 && n < 20) begin
            step();
            n++;
        end
        total++; if (n !== 5) begin bad++; $display("FAIL first_tick_latency got=%0d want=5 edges", n); end
        total++; if (pos !== 3'd1 || stp !== 1'b1) begin
            bad++; $display("FAIL first_tick_pos got=%0d/%b want=1/1", pos, stp);
        end
    endtask

    task automatic test_sweep();
        int k, kp, pulses;
        logic exp_stp;
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();  // IDLE -> UP edge
        pulses = 0;
        for (int c = 1; c <= 80; c++) begin
            step();
            k  = c / 4;
            kp = (c - 1) / 4;
            exp_stp = (c % 4 == 0) && (m_pos(k) != m_pos(kp));
            if (stp) pulses++;
            total++; if (pos !== 3'(m_pos(k))) begin bad++; $display("FAIL sweep_pos c=%0d got=%0d want=%0d", c, pos, m_pos(k)); end
            total++; if (dir !== m_dir(k))     begin bad++; $display("FAIL sweep_dir c=%0d got=%b want=%b", c, dir, m_dir(k)); end
            total++; if (stp !== exp_stp)      begin bad++; $display("FAIL sweep_step c=%0d got=%b want=%b", c, stp, exp_stp); end
            total++; if (leds !== m_leds(kp))  begin bad++; $display("FAIL sweep_leds c=%0d got=%h want=%h", c, leds, m_leds(kp)); end
        end
        total++; if (pulses !== 14) begin bad++; $display("FAIL sweep_pulses got=%0d want=14", pulses); end
    endtask

    task automatic test_pause();
        // Sweep ended right on a tick: UP, pos 0, count 0. Advance to count 2.
        repeat (2) step();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            total++; if (pos !== 3'd0 || stp !== 1'b0) begin
                bad++; $display("FAIL pause_hold i=%0d got=%0d/%b want=0/0", i, pos, stp);
            end
        end
        en = 1'b1;
        step();
        total++; if (pos !== 3'd0) begin bad++; $display("FAIL pause_resume1 got=%0d want=0", pos); end
        step();
        total++; if (pos !== 3'd1 || stp !== 1'b1) begin
            bad++; $display("FAIL pause_resume2 got=%0d/%b want=1/1", pos, stp);
        end
    endtask

    task automatic test_clear();
        // Just after tick 1; ticks 2..12 land at DOWN pos 5.
        repeat (44) step();
        total++; if (pos !== 3'd5 || dir !== 1'b1) begin
            bad++; $display("FAIL clear_setup got=%0d/%b want=5/1", pos, dir);
        end
        repeat (3) step();
        clr = 1'b1;  // coincides with tick 13
        step();
        total++; if (pos !== 3'd0) begin bad++; $display("FAIL clear_pos got=%0d want=0", pos); end
        total++; if (dir !== 1'b0) begin bad++; $display("FAIL clear_dir got=%b want=0", dir); end
        total++; if (stp !== 1'b0) begin bad++; $display("FAIL clear_step got=%b want=0", stp); end
        en = 1'b0;
        clr = 1'b0;
        repeat (6) step();
        total++; if (pos !== 3'd0 || stp !== 1'b0) begin
            bad++; $display("FAIL clear_idle got=%0d/%b want=0/0", pos, stp);
        end
    endtask

    task automatic test_invert();
        logic [7:0] exp_norm, exp_inv;
`ifdef LARSON_TRAIL_EN
        exp_norm = 8'h0C;
`else
        exp_norm = 8'h08;
`endif
        exp_inv = ~exp_norm;
        en = 1'b1;
        step();  // IDLE -> UP
        repeat (12) step();
        total++; if (pos !== 3'd3) begin bad++; $display("FAIL invert_setup got=%0d want=3", pos); end
        step();
        total++; if (leds !== exp_norm) begin bad++; $display("FAIL invert_plain got=%h want=%h", leds, exp_norm); end
        inv = 1'b1;
        total++; if (leds !== exp_norm) begin bad++; $display("FAIL invert_lag got=%h want=%h", leds, exp_norm); end
        step();
        total++; if (leds !== exp_inv) begin bad++; $display("FAIL invert_on got=%h want=%h", leds, exp_inv); end
        inv = 1'b0;
        step();
        total++; if (leds !== exp_norm) begin bad++; $display("FAIL invert_off got=%h want=%h", leds, exp_norm); end
    endtask

    task automatic test_edge_params();
        logic exp_p [6];
        logic exp_s [6];
        exp_p = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_s = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        en2 = 1'b1;
        step();  // IDLE -> UP
        for (int i = 0; i < 6; i++) begin
            total++; if (pos2 !== exp_p[i]) begin bad++; $display("FAIL edge_pos i=%0d got=%b want=%b", i, pos2, exp_p[i]); end
            total++; if (stp2 !== exp_s[i]) begin bad++; $display("FAIL edge_step i=%0d got=%b want=%b", i, stp2, exp_s[i]); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_pause();
        test_clear();
        test_invert();
        test_edge_params();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
